// File: rtl/ofdm_rx_ctrl_pkg.sv
// Shared types, default generics and helpers for the OFDM receive controller.
package ofdm_rx_ctrl_pkg;

    localparam int FRAME_BITS_DEF      = 256;
    localparam int TIMEOUT_SAMPLES_DEF = 4000;
    localparam int LEVEL_WIDTH_DEF     = 16;
    localparam int BITS_PER_STROBE     = 2;
    localparam int CNT_W               = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SEARCH,
        ST_RECEIVE,
        ST_DONE,
        ST_TIMEOUT
    } rx_state_e;

    typedef struct packed {
        logic data_valid;
        logic sym_start;
        logic sym_valid;
        logic rcv_valid;
    } rx_strobe_t;

    // Saturating add for the frame counters; they pin at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ofdm_rx_watchdog.sv
// Sample watchdog: counts input samples since the last sign of progress, saturating at limit.
module ofdm_rx_watchdog #(
    parameter int WD_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            tick,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (tick && (cnt_q < limit))
            cnt_d = cnt_q + WD_W'(1);
    end

    // Looks at the post-update count so expiry lines up with the sample that caused it.
    assign expired = (cnt_d >= limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ofdm_rx_ctrl.sv
// Frame-level control for the OFDM RX chain: init, symbol search, bit counting, timeout.
module ofdm_rx_ctrl
    import ofdm_rx_ctrl_pkg::*;
#(
    parameter int frame_bits_g      = FRAME_BITS_DEF,
    parameter int timeout_samples_g = TIMEOUT_SAMPLES_DEF,
    parameter int level_width_g     = LEVEL_WIDTH_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     enable_i,
    input  logic [level_width_g-1:0] min_level_cfg_i,
    input  logic                     rx_data_valid_i,
    input  logic                     rx_symbols_start_i,
    input  logic                     rx_symbols_valid_i,
    input  logic                     rx_rcv_data_valid_i,
    output logic                     sys_init_o,
    output logic [level_width_g-1:0] min_level_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     timeout_o,
    output logic [CNT_W-1:0]         symbol_cnt_o,
    output logic [CNT_W-1:0]         bit_cnt_o
);

    localparam int          WD_W         = $clog2(timeout_samples_g + 1);
    localparam logic [31:0] FRAME_BITS_U = frame_bits_g;

    rx_state_e                state_q, state_d;
    logic [CNT_W-1:0]         sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [level_width_g-1:0] level_q, level_d;
    logic                     init_q, init_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tmo_q, tmo_d;
    logic                     wd_clear, wd_tick, wd_expired;
    rx_strobe_t               stb;

    assign stb = '{data_valid: rx_data_valid_i, sym_start: rx_symbols_start_i,
                   sym_valid: rx_symbols_valid_i, rcv_valid: rx_rcv_data_valid_i};

    ofdm_rx_watchdog #(.WD_W(WD_W)) u_wd (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .limit   (WD_W'(timeout_samples_g)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        level_d   = level_q;
        wd_clear  = 1'b0;
        wd_tick   = 1'b0;
        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_INIT;
            ST_INIT: begin
                wd_clear = 1'b1;
                state_d  = ST_SEARCH;
            end
            ST_SEARCH: begin
                wd_tick = stb.data_valid;
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (stb.sym_start) begin
                    state_d   = ST_RECEIVE;
                    sym_cnt_d = CNT_W'(1);
                end else if (wd_expired) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_RECEIVE: begin
                wd_tick  = stb.data_valid;
                wd_clear = stb.sym_valid;
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (stb.sym_start && stb.sym_valid)
                        sym_cnt_d = sat_add(sym_cnt_q, 1);
                    if (stb.rcv_valid)
                        bit_cnt_d = sat_add(bit_cnt_q, BITS_PER_STROBE);
                    // A completed frame takes priority over a simultaneous watchdog expiry.
                    if ({16'd0, bit_cnt_d} >= FRAME_BITS_U)
                        state_d = ST_DONE;
                    else if (wd_expired)
                        state_d = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT: state_d = enable_i ? ST_INIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_INIT) begin
            sym_cnt_d = '0;
            bit_cnt_d = '0;
            level_d   = min_level_cfg_i;
        end

        init_d = (state_d == ST_INIT);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        tmo_d  = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
            level_q   <= '0;
            init_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            level_q   <= level_d;
            init_q    <= init_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    assign sys_init_o   = init_q;
    assign min_level_o  = level_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign timeout_o    = tmo_q;
    assign symbol_cnt_o = sym_cnt_q;
    assign bit_cnt_o    = bit_cnt_q;

endmodule

// File: tb/tb_ofdm_rx_ctrl.sv
// Bench for ofdm_rx_ctrl: directed corner cases plus randomized frames against a frame-level model.
module tb_ofdm_rx_ctrl;

    localparam int FB = 8;
    localparam int TO = 8;
    localparam int LW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          enable_i;
    logic [LW-1:0] min_level_cfg_i;
    logic          rx_data_valid_i, rx_symbols_start_i, rx_symbols_valid_i, rx_rcv_data_valid_i;
    logic          sys_init_o, busy_o, frame_done_o, timeout_o;
    logic [LW-1:0] min_level_o;
    logic [15:0]   symbol_cnt_o, bit_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    // Frame-level model: bits and symbols seen, samples since last progress, applied threshold.
    int m_bits, m_syms, m_wd, m_lvl;

    always #5 sys_clk = ~sys_clk;

    ofdm_rx_ctrl #(.frame_bits_g(FB), .timeout_samples_g(TO), .level_width_g(LW)) dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .enable_i            (enable_i),
        .min_level_cfg_i     (min_level_cfg_i),
        .rx_data_valid_i     (rx_data_valid_i),
        .rx_symbols_start_i  (rx_symbols_start_i),
        .rx_symbols_valid_i  (rx_symbols_valid_i),
        .rx_rcv_data_valid_i (rx_rcv_data_valid_i),
        .sys_init_o          (sys_init_o),
        .min_level_o         (min_level_o),
        .busy_o              (busy_o),
        .frame_done_o        (frame_done_o),
        .timeout_o           (timeout_o),
        .symbol_cnt_o        (symbol_cnt_o),
        .bit_cnt_o           (bit_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input int init, input int busy, input int done, input int tmo);
        chk({tag, ".init"}, 32'(sys_init_o), init);
        chk({tag, ".busy"}, 32'(busy_o), busy);
        chk({tag, ".done"}, 32'(frame_done_o), done);
        chk({tag, ".tmo"}, 32'(timeout_o), tmo);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".syms"}, 32'(symbol_cnt_o), m_syms);
        chk({tag, ".bits"}, 32'(bit_cnt_o), m_bits);
        chk({tag, ".lvl"}, 32'(min_level_o), m_lvl);
    endtask

    // Drive one cycle of strobes, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic dv, input logic st, input logic sv, input logic rcv);
        rx_data_valid_i     = dv;
        rx_symbols_start_i  = st;
        rx_symbols_valid_i  = sv;
        rx_rcv_data_valid_i = rcv;
        @(posedge sys_clk);
        #1;
        rx_data_valid_i     = 1'b0;
        rx_symbols_start_i  = 1'b0;
        rx_symbols_valid_i  = 1'b0;
        rx_rcv_data_valid_i = 1'b0;
    endtask

    // Called while the init pulse is visible; strobes here must be ignored.
    task automatic do_init(input string tag);
        chk_ctl({tag, ".in"}, 1, 1, 0, 0);
        cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        m_bits = 0;
        m_syms = 0;
        m_wd   = 0;
        m_lvl  = int'(min_level_cfg_i);
        chk_ctl({tag, ".srch"}, 0, 1, 0, 0);
        chk_cnt({tag, ".srch"});
    endtask

    // Frame finished (done or timeout visible); the next cycle must re-issue init.
    task automatic reinit(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        do_init(tag);
    endtask

    task automatic search_samples(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                chk_ctl({tag, ".gap"}, 0, 1, 0, 0);
            end
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            m_wd = (m_wd + 1 > TO) ? TO : m_wd + 1;
            chk_ctl($sformatf("%s.smp%0d", tag, i), 0, 1, 0, (m_wd >= TO) ? 1 : 0);
        end
        chk_cnt({tag, ".smp"});
    endtask

    task automatic do_start(input logic dv, input string tag);
        cyc(dv, 1'b1, 1'b1, 1'b0);
        m_syms = 1;
        m_wd   = (m_wd + int'(dv) > TO) ? TO : m_wd + int'(dv);
        chk_ctl({tag, ".start"}, 0, 1, 0, 0);
        chk_cnt({tag, ".start"});
    endtask

    task automatic recv_random(input string tag);
        int guard = 0;
        while (m_bits < FB && guard < 200) begin
            logic rcv, sv, st, dv;
            guard++;
            rcv = 1'($urandom);
            sv  = (m_wd >= TO - 1) ? 1'b1 : 1'($urandom);
            st  = sv & 1'($urandom);
            dv  = (m_wd < TO - 2) ? 1'($urandom) : 1'b0;
            if ($urandom_range(0, 3) == 0) min_level_cfg_i = LW'($urandom);
            cyc(dv, st, sv, rcv);
            if (sv) m_wd = 0;
            else    m_wd = m_wd + int'(dv);
            m_bits = m_bits + 2 * int'(rcv);
            m_syms = m_syms + int'(st & sv);
            chk_ctl({tag, ".rx"}, 0, 1, (m_bits >= FB) ? 1 : 0, 0);
            chk_cnt({tag, ".rx"});
        end
        chk({tag, ".guard"}, 32'(m_bits >= FB), 1);
    endtask

    initial begin
        sys_rst = 1'b1;
        enable_i = 1'b0;
        min_level_cfg_i = '0;
        rx_data_valid_i = 1'b0;
        rx_symbols_start_i = 1'b0;
        rx_symbols_valid_i = 1'b0;
        rx_rcv_data_valid_i = 1'b0;
        m_bits = 0; m_syms = 0; m_wd = 0; m_lvl = 0;

        repeat (2) @(posedge sys_clk);
        #1;
        chk_ctl("rst", 0, 0, 0, 0);
        chk_cnt("rst");
        sys_rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk_ctl("idle", 0, 0, 0, 0);
        chk_cnt("idle");

        // Power-up init with a fixed threshold.
        min_level_cfg_i = 16'd42752;
        enable_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        do_init("init0");
        chk("init0.lvl_abs", 32'(min_level_o), 42752);

        // Start after 3 samples, 4 rcv strobes complete the frame.
        search_samples(3, "f1");
        do_start(1'b0, "f1");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            m_bits += 2;
            chk_ctl("f1.rx", 0, 1, (i == 3) ? 1 : 0, 0);
        end
        chk("f1.bits8", 32'(bit_cnt_o), 8);
        reinit("f1");

        // Eight samples without a start time out in SEARCH.
        search_samples(TO, "tos");
        reinit("tos");

        // Frame completion and watchdog expiry on the same cycle: done wins.
        do_start(1'b0, "tie");
        for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, 1'b0, 1'b1); m_bits += 2; m_wd++; end
        for (int i = 0; i < 4; i++) begin cyc(1'b1, 1'b0, 1'b0, 1'b0); m_wd++; end
        chk_ctl("tie.pre", 0, 1, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        m_bits += 2;
        chk_ctl("tie.end", 0, 1, 1, 0);
        chk_cnt("tie.end");
        reinit("tie");

        // Watchdog expiry in RECEIVE with too few bits.
        do_start(1'b0, "tor");
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        m_bits = 2;
        m_wd = 0;
        search_samples(TO, "tor");
        reinit("tor");

        // Start together with the expiring sample: start wins.
        search_samples(TO - 1, "sw");
        do_start(1'b1, "sw");
        recv_random("sw");
        reinit("sw");

        // Randomized frames and search timeouts back to back.
        for (int k = 0; k < 14; k++) begin
            string tg = $sformatf("rnd%0d", k);
            if ($urandom_range(0, 3) == 0) begin
                search_samples(TO, tg);
            end else begin
                search_samples($urandom_range(0, TO - 2), tg);
                do_start(1'($urandom), tg);
                recv_random(tg);
            end
            reinit(tg);
        end

        // Drop enable mid-RECEIVE: straight to idle, counters held, no pulse.
        do_start(1'b0, "drop");
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        m_bits = 4;
        enable_i = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctl("drop", 0, 0, 0, 0);
        chk_cnt("drop");
        for (int i = 0; i < 3; i++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            chk_ctl("drop.idle", 0, 0, 0, 0);
            chk_cnt("drop.idle");
        end

        // Re-enable, then hit reset mid-SEARCH.
        min_level_cfg_i = LW'($urandom);
        enable_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        do_init("re");
        search_samples(2, "re");
        #3;
        sys_rst = 1'b1;
        enable_i = 1'b0;
        #1;
        m_bits = 0; m_syms = 0; m_lvl = 0;
        chk_ctl("arst", 0, 0, 0, 0);
        chk_cnt("arst");
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1);
            chk_ctl("post", 0, 0, 0, 0);
            chk_cnt("post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
